// File: rtl/mont_loop_ctrl.sv
// Radix-16 Montgomery loop sequencer feeding the carry-save adder: gated B/M multiples, shift
// strobe, phase codes and subtract passes. Define MONT_LOOP_CTRL_CYCLE_CNT_EN to add cycle_count.
module mont_loop_ctrl #(
    parameter int unsigned N       = 512,
    parameter int unsigned DIGIT   = 4,
    parameter int unsigned MAX_SUB = 3
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic [N-1:0]   M,
    input  logic [N-1:0]   M_neg,
    input  logic [7:0]     cPrediction,
    input  logic           subtract_finished,
    output logic [N-1:0]   B0,
    output logic [N:0]     B1,
    output logic [N+1:0]   B2,
    output logic [N+2:0]   B3,
    output logic [N-1:0]   M0,
    output logic [N:0]     M1,
    output logic [N+1:0]   M2,
    output logic [N+2:0]   M3,
    output logic [N-1:0]   subtraction,
    output logic           c_doubleshift,
    output logic           subtract,
    output logic [3:0]     phase,
    output logic           busy,
    output logic           done,
`ifdef MONT_LOOP_CTRL_CYCLE_CNT_EN
    output logic           error,
    output logic [15:0]    cycle_count
`else
    output logic           error
`endif
);

    localparam int unsigned ITERS = N / DIGIT;
    localparam int unsigned JW    = $clog2(ITERS);
    localparam int unsigned PW    = (MAX_SUB > 1) ? $clog2(MAX_SUB) : 1;

    typedef enum logic [2:0] {StIdle, StIter, StFinal, StSub, StDone, StErr} state_e;

    state_e          state_q, state_d;
    logic [JW-1:0]   j_q, j_d;
    logic [2:0]      ph_q, ph_d;
    logic [PW-1:0]   p_q, p_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d, m_q, m_d, mneg_q, mneg_d;

    // Only the low nibble of the prediction is the quotient digit.
    logic unused_cpred;
    assign unused_cpred = ^cPrediction[7:4];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            j_q     <= '0;
            ph_q    <= '0;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            mneg_q  <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            ph_q    <= ph_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            mneg_q  <= mneg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        ph_d    = ph_q;
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        mneg_d  = mneg_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    m_d     = M;
                    mneg_d  = M_neg;
                    j_d     = '0;
                    state_d = StIter;
                end
            end
            StIter: begin
                a_d  = a_q >> DIGIT;
                j_d  = j_q + 1'b1;
                ph_d = '0;
                if (j_q == JW'(ITERS - 1)) state_d = StFinal;
            end
            StFinal: begin
                ph_d = ph_q + 3'd1;
                if (ph_q == 3'd5) begin
                    ph_d    = '0;
                    p_d     = '0;
                    state_d = StSub;
                end
            end
            StSub: begin
                ph_d = ph_q + 3'd1;
                if (ph_q == 3'd5) begin
                    ph_d = '0;
                    if (subtract_finished) state_d = StDone;
                    else if (p_q == PW'(MAX_SUB - 1)) state_d = StErr;
                    else p_d = p_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        B0            = '0;
        B1            = '0;
        B2            = '0;
        B3            = '0;
        M0            = '0;
        M1            = '0;
        M2            = '0;
        M3            = '0;
        c_doubleshift = 1'b0;
        subtract      = 1'b0;
        phase         = 4'd8;
        busy          = 1'b0;
        done          = 1'b0;
        error         = 1'b0;
        unique case (state_q)
            StIter: begin
                busy          = 1'b1;
                c_doubleshift = 1'b1;
                B0 = a_q[0] ? b_q : '0;
                B1 = a_q[1] ? {b_q, 1'b0} : '0;
                B2 = a_q[2] ? {b_q, 2'b0} : '0;
                B3 = a_q[3] ? {b_q, 3'b0} : '0;
                M0 = cPrediction[0] ? m_q : '0;
                M1 = cPrediction[1] ? {m_q, 1'b0} : '0;
                M2 = cPrediction[2] ? {m_q, 2'b0} : '0;
                M3 = cPrediction[3] ? {m_q, 3'b0} : '0;
            end
            StFinal: begin
                busy  = 1'b1;
                phase = {1'b0, ph_q};
            end
            StSub: begin
                busy     = 1'b1;
                subtract = 1'b1;
                phase    = {1'b0, ph_q};
            end
            StDone:  done  = 1'b1;
            StErr:   error = 1'b1;
            default: ;
        endcase
    end

    assign subtraction = mneg_q;

`ifdef MONT_LOOP_CTRL_CYCLE_CNT_EN
    logic [15:0] cnt_q;

    // The accepting IDLE cycle counts as the first busy cycle.
    always_ff @(posedge clk) begin
        if (!resetn) cnt_q <= '0;
        else if (state_q == StIdle && start) cnt_q <= 16'd1;
        else if (busy && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end

    assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_mont_loop_ctrl.sv
// Self-checking bench for mont_loop_ctrl: a cycle-offset model predicts every output each cycle,
// and directed runs pin gating, latency, pass counts, start-while-busy and mid-run reset.
module tb_mont_loop_ctrl;

    localparam int N       = 512;
    localparam int MAX_SUB = 3;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           start = 1'b0;
    logic           subtract_finished = 1'b0;
    logic [N-1:0]   A = '0, B = '0, M = '0, M_neg = '0;
    logic [7:0]     cPrediction = '0;
    logic [N-1:0]   B0, M0, subtraction;
    logic [N:0]     B1, M1;
    logic [N+1:0]   B2, M2;
    logic [N+2:0]   B3, M3;
    logic           c_doubleshift, subtract, busy, done, error;
    logic [3:0]     phase;
`ifdef MONT_LOOP_CTRL_CYCLE_CNT_EN
    logic [15:0]    cycle_count;
`endif

    mont_loop_ctrl #(.N(N), .DIGIT(4), .MAX_SUB(MAX_SUB)) dut (
        .clk(clk), .resetn(resetn), .start(start), .A(A), .B(B), .M(M), .M_neg(M_neg),
        .cPrediction(cPrediction), .subtract_finished(subtract_finished),
        .B0(B0), .B1(B1), .B2(B2), .B3(B3), .M0(M0), .M1(M1), .M2(M2), .M3(M3),
        .subtraction(subtraction), .c_doubleshift(c_doubleshift), .subtract(subtract),
        .phase(phase), .busy(busy), .done(done),
`ifdef MONT_LOOP_CTRL_CYCLE_CNT_EN
        .error(error), .cycle_count(cycle_count)
`else
        .error(error)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: t = cycles since the accepting edge (0 = idle).
    int t = 0;
    int fin_pass = -1;
    int cyc = 0;
    int cc_hold = 0;
    bit chk_en = 0;
    logic [N-1:0] a_lat = '0, b_lat = '0, m_lat = '0, mneg_lat = '0;

    int n_cds = 0, n_subc = 0;
    bit got_done = 0;

    function automatic int end_t(input int fp);
        return (fp >= 0 && fp < MAX_SUB) ? 135 + 6 * (fp + 1) : 135 + 6 * MAX_SUB;
    endfunction

    function automatic logic [N+3:0] lit(input int unsigned v);
        return {{(N-28){1'b0}}, v};
    endfunction

    task automatic chk(input string name, input logic [N+3:0] got, input logic [N+3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, exp);
        end
    endtask

    task automatic chk_s(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!resetn) begin
            t        <= 0;
            mneg_lat <= '0;
            cc_hold  <= 0;
        end else if (t == 0) begin
            if (start) begin
                t        <= 1;
                a_lat    <= A;
                b_lat    <= B;
                m_lat    <= M;
                mneg_lat <= M_neg;
            end
        end else if (t == end_t(fin_pass)) begin
            t       <= 0;
            cc_hold <= t;
        end else begin
            t <= t + 1;
        end
    end

    // Quotient digits and subtract_finished; spurious finished pulses outside SUB must be ignored.
    always @(posedge clk) begin
        #1;
        cPrediction = (t == 1) ? 8'h0A : 8'(t * 37 + 5);
        if (t >= 135 && t < end_t(fin_pass))
            subtract_finished = ((t - 135) / 6 == fin_pass) && ((t - 135) % 6 == 5);
        else
            subtract_finished = (t >= 1 && t <= 134 && t[0]);
    end

    always @(negedge clk) begin : cmp
        logic [N+3:0] eb [4];
        logic [N+3:0] em [4];
        logic [N-1:0] sh;
        logic [3:0]   d, ep;
        int           ecds, esub, ebusy, edone, eerr, et;
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                eb[k] = '0;
                em[k] = '0;
            end
            ep = 4'd8; ecds = 0; esub = 0; ebusy = 0; edone = 0; eerr = 0;
            sh = '0; d = '0;
            et = end_t(fin_pass);
            if (t >= 1 && t <= 128) begin
                sh    = a_lat >> (4 * (t - 1));
                d     = sh[3:0];
                ecds  = 1;
                ebusy = 1;
                for (int k = 0; k < 4; k++) begin
                    eb[k] = d[k] ? ({4'b0, b_lat} << k) : '0;
                    em[k] = cPrediction[k] ? ({4'b0, m_lat} << k) : '0;
                end
            end else if (t >= 129 && t <= 134) begin
                ebusy = 1;
                ep    = 4'(t - 129);
            end else if (t >= 135 && t < et) begin
                ebusy = 1;
                esub  = 1;
                ep    = 4'((t - 135) % 6);
            end else if (t >= 1 && t == et) begin
                if (fin_pass >= 0 && fin_pass < MAX_SUB) edone = 1;
                else eerr = 1;
            end
            chk("B0", {4'b0, B0}, eb[0]);
            chk("B1", {3'b0, B1}, eb[1]);
            chk("B2", {2'b0, B2}, eb[2]);
            chk("B3", {1'b0, B3}, eb[3]);
            chk("M0", {4'b0, M0}, em[0]);
            chk("M1", {3'b0, M1}, em[1]);
            chk("M2", {2'b0, M2}, em[2]);
            chk("M3", {1'b0, M3}, em[3]);
            chk("subtraction", {4'b0, subtraction}, {4'b0, mneg_lat});
            chk_s("phase", int'(phase), int'(ep));
            chk_s("c_doubleshift", int'(c_doubleshift), ecds);
            chk_s("subtract", int'(subtract), esub);
            chk_s("busy", int'(busy), ebusy);
            chk_s("done", int'(done), edone);
            chk_s("error", int'(error), eerr);
`ifdef MONT_LOOP_CTRL_CYCLE_CNT_EN
            chk_s("cycle_count", int'(cycle_count), (t >= 1) ? t : cc_hold);
`endif
            if (t == 1) begin
                n_cds  = 0;
                n_subc = 0;
            end
            n_cds  += int'(c_doubleshift);
            n_subc += int'(subtract);
            if (done) got_done = 1;
        end
    end

    task automatic run(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m,
                       input int fp, input int exp_len, input int exp_sub, input bit exp_done,
                       input bit gate, input bit poke);
        int st;
        bit ended;
        ended = 0;
        @(negedge clk);
        A = a; B = b; M = m; M_neg = -m;
        fin_pass = fp;
        got_done = 0;
        start = 1;
        st = cyc;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            start = poke && (i >= 3 && i < 6);
            if (i == 1) begin
                A = ~a; B = ~b; M = ~m; M_neg = ~M_neg;
            end
            if (gate && i == 1) begin
                chk("gate_B0", {4'b0, B0}, lit(1));
                chk("gate_B1", {3'b0, B1}, lit(0));
                chk("gate_B2", {2'b0, B2}, lit(4));
                chk("gate_B3", {1'b0, B3}, lit(0));
                chk("gate_M0", {4'b0, M0}, lit(0));
                chk("gate_M1", {3'b0, M1}, lit(6));
                chk("gate_M2", {2'b0, M2}, lit(0));
                chk("gate_M3", {1'b0, M3}, lit(24));
            end
            if (gate && i == 2) begin
                chk("gate2_B", {4'b0, B0} | {3'b0, B1} | {2'b0, B2} | {1'b0, B3}, lit(0));
            end
            if (done || error) begin
                ended = 1;
                break;
            end
        end
        start = 0;
        #1;
        chk_s("run_ended", int'(ended), 1);
        chk_s("run_len", cyc - st + 1, exp_len);
        chk_s("cds_count", n_cds, 128);
        chk_s("sub_count", n_subc, exp_sub);
        chk_s("done_seen", int'(got_done), int'(exp_done));
`ifdef MONT_LOOP_CTRL_CYCLE_CNT_EN
        chk_s("cycle_count_end", int'(cycle_count), exp_len - 1);
`endif
    endtask

    initial begin
        int nd;
        resetn = 0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        resetn = 1;
        repeat (10) @(negedge clk);
        chk_s("rst_phase", int'(phase), 8);
        chk_s("rst_busy", int'(busy), 0);
        chk("rst_B3", {1'b0, B3}, lit(0));

        // Gating digits, single pass, 142 cycles.
        run(512'h5, 512'h1, 512'h3, 0, 142, 6, 1, 1, 0);
`ifdef MONT_LOOP_CTRL_CYCLE_CNT_EN
        @(negedge clk);
        chk_s("cycle_count_hold", int'(cycle_count), 141);
`endif
        // Back-to-back start, wide operands, starts poked during ITER.
        run({16{32'hDEADBEEF}}, {16{32'h12345678}}, {16{32'hF0F0A5A5}} | 512'h1,
            0, 142, 6, 1, 0, 1);
        // Finished only on third pass.
        run({8{64'h0123456789ABCDEF}}, {8{64'hFEDCBA9876543210}}, {16{32'h8000_0001}},
            2, 154, 18, 1, 0, 0);
        // Never finished: error after MAX_SUB passes.
        run({16{32'hA5A5_5A5A}}, {16{32'h3333_CCCC}}, 512'h7, -1, 154, 18, 0, 0, 0);

        // Reset during SUB.
        @(negedge clk);
        A = {16{32'h1111_2222}}; B = 512'h9; M = 512'hB; M_neg = -512'hB;
        fin_pass = -1;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (136) @(negedge clk);
        chk_s("pre_rst_sub", int'(subtract), 1);
        resetn = 0;
        @(negedge clk);
        resetn = 1;
        chk_s("mid_rst_phase", int'(phase), 8);
        chk_s("mid_rst_busy", int'(busy), 0);
        chk_s("mid_rst_subtract", int'(subtract), 0);
        chk("mid_rst_subtraction", {4'b0, subtraction}, lit(0));
        nd = 0;
        repeat (200) begin
            @(negedge clk);
            nd += int'(done) + int'(error);
        end
        chk_s("no_end_after_rst", nd, 0);
        run(512'hF, 512'h2, 512'h5, 0, 142, 6, 1, 0, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
